crack_scheduler: RTL and testbench

- Key-space scheduler for the multi-core ARC4 cracker.
- Hands candidate keys to NUM_CORES crack cores using round-robin dispatch.
- Tracks the key each core is working on and collects hit/miss results.
- Reports the smallest key that produced a valid plaintext, or "not found" once the space is exhausted. Sits between the top-level control (KEY[3] reset, start) and the crack core array; its key output drives the HEX display logic.

---
 rtl/crack_scheduler_if.sv | 53 +++++
 rtl/crack_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_crack_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crack_scheduler_if.sv
// Scheduler-side bundle: control handshake, result, and crack-core array signals.
// Optional stats port keys_tried exists only when CRACK_SCHED_STATS_EN is defined.
interface crack_scheduler_if #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned KEY_W     = 24
);
  // top-level control and result
  logic                 en;
  logic                 rdy;
  logic                 key_valid;
  logic [KEY_W-1:0]     key;
  // crack core array
  logic [NUM_CORES-1:0] core_en;
  logic [KEY_W-1:0]     core_key;
  logic [NUM_CORES-1:0] core_rdy;
  logic [NUM_CORES-1:0] core_done;
  logic [NUM_CORES-1:0] core_hit;
`ifdef CRACK_SCHED_STATS_EN
  logic [KEY_W:0]       keys_tried;
`endif

  // driver side: control block plus core array
  modport master (
    output en,
    output core_rdy,
    output core_done,
    output core_hit,
    input  rdy,
    input  key_valid,
    input  key,
    input  core_en,
    input  core_key
`ifdef CRACK_SCHED_STATS_EN
    , input keys_tried
`endif
  );

  // scheduler side
  modport slave (
    input  en,
    input  core_rdy,
    input  core_done,
    input  core_hit,
    output rdy,
    output key_valid,
    output key,
    output core_en,
    output core_key
`ifdef CRACK_SCHED_STATS_EN
    , output keys_tried
`endif
  );
endinterface

// File: rtl/crack_scheduler.sv
// Key-space scheduler for the multi-core ARC4 cracker.
// Hands keys 0..2^KEY_W-1 to crack cores round-robin, tracks the key each core
// holds, and reports the smallest hit key (or none) once the run drains.
// Optional feature macro: CRACK_SCHED_STATS_EN adds the keys_tried counter.
module crack_scheduler #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned KEY_W     = 24
) (
  input logic              clk,
  input logic              rst_n,
  crack_scheduler_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [KEY_W-1:0] KEY_MAX = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_DRAIN    = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 rdy_q, rdy_d;
  logic                 key_valid_q, key_valid_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic [NUM_CORES-1:0] core_en_q, core_en_d;
  logic [KEY_W-1:0]     core_key_q, core_key_d;
  logic [NUM_CORES-1:0] busy_q, busy_d;
  logic [KEY_W-1:0]     assigned_q [NUM_CORES];
  logic [KEY_W-1:0]     assigned_d [NUM_CORES];
  logic [KEY_W-1:0]     next_key_q, next_key_d;
  logic                 exhausted_q, exhausted_d;
  logic [IDX_W-1:0]     last_q, last_d;

  logic [NUM_CORES-1:0] done_v;
  logic [NUM_CORES-1:0] hit_v;
  logic [NUM_CORES-1:0] elig;
  logic                 start;
  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;
  int unsigned          cand;
  logic                 best_valid;
  logic [KEY_W-1:0]     best_key;

  // Results only count for cores actually holding a key.
  assign done_v = bus.core_done & busy_q;
  assign hit_v  = done_v & bus.core_hit;
  assign elig   = bus.core_rdy & ~busy_q;
  assign start  = (state_q == S_IDLE) && bus.en;

  // Round-robin pick: first eligible core after the last one dispatched.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= NUM_CORES; i++) begin
      cand = 32'(last_q) + i;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      if (!sel_found && elig[IDX_W'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end
  end

  // Minimum over this cycle's hit keys and the key already held.
  always_comb begin
    best_valid = key_valid_q;
    best_key   = key_q;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (hit_v[IDX_W'(i)] &&
          (!best_valid || (assigned_q[IDX_W'(i)] < best_key))) begin
        best_valid = 1'b1;
        best_key   = assigned_q[IDX_W'(i)];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rdy_d       = rdy_q;
    key_valid_d = best_valid;
    key_d       = best_key;
    core_en_d   = '0;
    core_key_d  = core_key_q;
    busy_d      = busy_q & ~done_v;
    assigned_d  = assigned_q;
    next_key_d  = next_key_q;
    exhausted_d = exhausted_q;
    last_d      = last_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          state_d     = S_DISPATCH;
          rdy_d       = 1'b0;
          key_valid_d = 1'b0;
          key_d       = '0;
          next_key_d  = '0;
          exhausted_d = 1'b0;
          last_d      = LAST_IDX;
        end
      end

      S_DISPATCH: begin
        if (sel_found && !exhausted_q) begin
          core_en_d[sel_idx]  = 1'b1;
          core_key_d          = next_key_q;
          assigned_d[sel_idx] = next_key_q;
          busy_d[sel_idx]     = 1'b1;
          last_d              = sel_idx;
          // Last key of the space: stop here instead of wrapping to 0.
          if (next_key_q == KEY_MAX) begin
            exhausted_d = 1'b1;
            state_d     = S_DRAIN;
          end else begin
            next_key_d = next_key_q + KEY_W'(1);
          end
        end
        // A hit ends dispatching; a same-cycle dispatch above still goes out.
        if (|hit_v) state_d = S_DRAIN;
      end

      S_DRAIN: begin
        if (busy_q == '0) begin
          state_d = S_IDLE;
          rdy_d   = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        rdy_d   = 1'b1;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q       <= 1'b1;
      key_valid_q <= 1'b0;
      key_q       <= '0;
      core_en_q   <= '0;
      core_key_q  <= '0;
      busy_q      <= '0;
      assigned_q  <= '{default: '0};
      next_key_q  <= '0;
      exhausted_q <= 1'b0;
      last_q      <= LAST_IDX;
    end else begin
      rdy_q       <= rdy_d;
      key_valid_q <= key_valid_d;
      key_q       <= key_d;
      core_en_q   <= core_en_d;
      core_key_q  <= core_key_d;
      busy_q      <= busy_d;
      assigned_q  <= assigned_d;
      next_key_q  <= next_key_d;
      exhausted_q <= exhausted_d;
      last_q      <= last_d;
    end
  end

  assign bus.rdy       = rdy_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key       = key_q;
  assign bus.core_en   = core_en_q;
  assign bus.core_key  = core_key_q;

`ifdef CRACK_SCHED_STATS_EN
  localparam int unsigned CNT_W = KEY_W + 1;
  localparam int unsigned SUM_W = KEY_W + 2;
  localparam logic [CNT_W-1:0] TRIED_MAX = CNT_W'(1) << KEY_W;

  logic [CNT_W-1:0] tried_q, tried_d;
  logic [SUM_W-1:0] done_cnt;
  logic [SUM_W-1:0] tried_sum;

  // Count accepted core_done pulses, saturating at the key-space size.
  always_comb begin
    done_cnt = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      done_cnt = done_cnt + SUM_W'(done_v[IDX_W'(i)]);
    end
    tried_sum = SUM_W'(tried_q) + done_cnt;
    if (start)                              tried_d = '0;
    else if (tried_sum > SUM_W'(TRIED_MAX)) tried_d = TRIED_MAX;
    else                                    tried_d = CNT_W'(tried_sum);
  end

  // Stats counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tried_q <= '0;
    else        tried_q <= tried_d;
  end

  assign bus.keys_tried = tried_q;
`endif

endmodule

// File: tb/tb_crack_scheduler.sv
`timescale 1ns/1ps
module tb_crack_scheduler;
  localparam int unsigned NC    = 2;
  localparam int unsigned KW    = 4;
  localparam int unsigned NKEYS = 1 << KW;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  crack_scheduler_if #(.NUM_CORES(NC), .KEY_W(KW)) bus ();
  crack_scheduler #(.NUM_CORES(NC), .KEY_W(KW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    int              cyc;
    logic [NC-1:0]   oh;
    int              key;
    bit              free;
  } disp_t;

  disp_t log_q[$];
  int    cyc = 0;
  int    first_hit = -1;
  int    lat_tab [NKEYS];
  bit    hit_tab [NKEYS];
  int    timer   [NC];
  int    held    [NC];
  int    last_done [NC];
  int    checks = 0;
  int    errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Crack-core array model: per-key latency and hit tables, logs every dispatch.
  always @(negedge clk) begin
    logic [NC-1:0] d;
    logic [NC-1:0] h;
    bit            idle_b [NC];
    disp_t         e;
    d = '0;
    h = '0;
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) begin
        timer[i] = 0;
        last_done[i] = -100;
      end
    end else begin
      for (int i = 0; i < NC; i++) begin
        idle_b[i] = (timer[i] == 0);
        if (timer[i] > 0) begin
          timer[i]--;
          if (timer[i] == 0) begin
            d[i] = 1'b1;
            h[i] = hit_tab[held[i]];
            last_done[i] = cyc;
          end
        end
      end
      if (bus.core_en != '0) begin
        e.cyc  = cyc;
        e.oh   = bus.core_en;
        e.key  = int'(bus.core_key);
        e.free = 1'b1;
        for (int i = 0; i < NC; i++) begin
          if (bus.core_en[i]) begin
            if (!idle_b[i] || last_done[i] > cyc - 2 || !bus.core_rdy[i]) e.free = 1'b0;
            timer[i] = lat_tab[e.key];
            held[i]  = e.key;
          end
        end
        log_q.push_back(e);
      end
      if ((d & h) != '0 && first_hit < 0) first_hit = cyc;
    end
    bus.core_done = d;
    bus.core_hit  = h;
  end

  // Reference result: smallest dispatched key whose table entry is a hit.
  function automatic void model_result(output bit v, output int k);
    v = 1'b0;
    k = 0;
    foreach (log_q[i]) begin
      if (hit_tab[log_q[i].key] && (!v || log_q[i].key < k)) begin
        v = 1'b1;
        k = log_q[i].key;
      end
    end
  endfunction

  // Reference dispatch rules: keys 0,1,2.. in order, one-hot, to a free ready core.
  function automatic int log_errors();
    int n = 0;
    foreach (log_q[i]) begin
      if (log_q[i].key != i) n++;
      if ($countones(log_q[i].oh) != 1) n++;
      if (!log_q[i].free) n++;
    end
    return n;
  endfunction

  function automatic int late_dispatches();
    int n = 0;
    if (first_hit >= 0)
      foreach (log_q[i]) if (log_q[i].cyc > first_hit + 1) n++;
    return n;
  endfunction

  task automatic set_tabs(input int lat);
    for (int k = 0; k < NKEYS; k++) begin
      lat_tab[k] = lat;
      hit_tab[k] = 1'b0;
    end
  endtask

  task automatic start_run(output int e_cyc);
    log_q.delete();
    first_hit = -1;
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    e_cyc = cyc;
    bus.en = 1'b0;
  endtask

  task automatic wait_idle(output bit to);
    to = 1'b1;
    for (int n = 0; n < 2000 && to; n++) begin
      @(posedge clk);
      #1;
      if (bus.rdy) to = 1'b0;
    end
  endtask

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 500 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (bus.key_valid) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.core_rdy = '1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %0b exp 1", bus.rdy); end
    checks++; if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid got %0b exp 0", bus.key_valid); end
    checks++; if (bus.key !== '0) begin errors++; $display("FAIL reset_key got %0d exp 0", bus.key); end
    checks++; if (bus.core_en !== '0) begin errors++; $display("FAIL reset_core_en got %b exp 0", bus.core_en); end
    checks++; if (bus.core_key !== '0) begin errors++; $display("FAIL reset_core_key got %0d exp 0", bus.core_key); end
`ifdef CRACK_SCHED_STATS_EN
    checks++; if (bus.keys_tried !== '0) begin errors++; $display("FAIL reset_keys_tried got %0d exp 0", bus.keys_tried); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.core_en !== '0 || bus.rdy !== 1'b1) begin errors++; $display("FAIL idle_quiet got core_en=%b rdy=%0b exp core_en=0 rdy=1", bus.core_en, bus.rdy); end
  endtask

  task automatic test_hit9();
    int e; bit to; int maxk; int alt;
    set_tabs(3);
    hit_tab[9] = 1'b1;
    start_run(e);
    checks++; if (bus.rdy !== 1'b0) begin errors++; $display("FAIL hit9_rdy_low got %0b exp 0", bus.rdy); end
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL hit9_timeout got timeout exp rdy"); end
    checks++; if (log_q.size() == 0 || log_q[0].cyc != e + 1) begin errors++; $display("FAIL hit9_first_latency got %0d exp %0d", (log_q.size() > 0) ? log_q[0].cyc - e : -1, 1); end
    alt = 0; maxk = -1;
    foreach (log_q[i]) begin
      if (log_q[i].oh != NC'(1 << (i % 2))) alt++;
      if (log_q[i].key > maxk) maxk = log_q[i].key;
    end
    checks++; if (alt != 0) begin errors++; $display("FAIL hit9_alternation got %0d bad exp 0", alt); end
    checks++; if (log_errors() != 0) begin errors++; $display("FAIL hit9_sequence got %0d bad exp 0", log_errors()); end
    checks++; if (maxk > 10 || maxk < 9) begin errors++; $display("FAIL hit9_max_key got %0d exp 9..10", maxk); end
    checks++; if (bus.key !== KW'(9)) begin errors++; $display("FAIL hit9_key got %0d exp 9", bus.key); end
    checks++; if (bus.key_valid !== 1'b1) begin errors++; $display("FAIL hit9_valid got %0b exp 1", bus.key_valid); end
  endtask

  task automatic test_exhaust();
    int e; bit to;
    set_tabs(3);
    start_run(e);
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL exhaust_timeout got timeout exp rdy"); end
    checks++; if (log_q.size() != NKEYS) begin errors++; $display("FAIL exhaust_count got %0d exp %0d", log_q.size(), NKEYS); end
    checks++; if (log_errors() != 0) begin errors++; $display("FAIL exhaust_sequence got %0d bad exp 0", log_errors()); end
    checks++; if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL exhaust_valid got %0b exp 0", bus.key_valid); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (bus.core_en !== '0) begin errors++; $display("FAIL exhaust_no_wrap got %b exp 0", bus.core_en); end
`ifdef CRACK_SCHED_STATS_EN
    checks++; if (bus.keys_tried !== (KW+1)'(NKEYS)) begin errors++; $display("FAIL exhaust_keys_tried got %0d exp %0d", bus.keys_tried, NKEYS); end
`endif
  endtask

  task automatic test_same_cycle_hits();
    int e; bit to; bit seen;
    set_tabs(3);
    lat_tab[4] = 4;
    hit_tab[4] = 1'b1;
    hit_tab[5] = 1'b1;
    start_run(e);
    wait_valid(seen);
    checks++; if (!seen) begin errors++; $display("FAIL same_cycle_seen got none exp valid"); end
    checks++; if (bus.key !== KW'(4)) begin errors++; $display("FAIL same_cycle_first_key got %0d exp 4", bus.key); end
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL same_cycle_timeout got timeout exp rdy"); end
    checks++; if (bus.key !== KW'(4) || bus.key_valid !== 1'b1) begin errors++; $display("FAIL same_cycle_final got %0d/%0b exp 4/1", bus.key, bus.key_valid); end
  endtask

  task automatic test_drain_hit();
    int e; bit to; bit seen;
    set_tabs(2);
    lat_tab[1] = 20;
    hit_tab[1] = 1'b1;
    hit_tab[4] = 1'b1;
    start_run(e);
    wait_valid(seen);
    checks++; if (!seen) begin errors++; $display("FAIL drain_seen got none exp valid"); end
    checks++; if (bus.key !== KW'(4) || bus.rdy !== 1'b0) begin errors++; $display("FAIL drain_first got key=%0d rdy=%0b exp key=4 rdy=0", bus.key, bus.rdy); end
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL drain_timeout got timeout exp rdy"); end
    checks++; if (bus.key !== KW'(1) || bus.key_valid !== 1'b1) begin errors++; $display("FAIL drain_late_hit got %0d/%0b exp 1/1", bus.key, bus.key_valid); end
  endtask

  task automatic test_core1_not_rdy();
    int e; bit to; int bad;
    set_tabs(2);
    bus.core_rdy = NC'(1);
    start_run(e);
    wait_idle(to);
    bad = 0;
    foreach (log_q[i]) if (log_q[i].oh != NC'(1)) bad++;
    checks++; if (to) begin errors++; $display("FAIL norobin_timeout got timeout exp rdy"); end
    checks++; if (bad != 0) begin errors++; $display("FAIL norobin_core1_used got %0d exp 0", bad); end
    checks++; if (log_q.size() != NKEYS || log_errors() != 0) begin errors++; $display("FAIL norobin_sequence got %0d keys %0d bad exp %0d keys 0 bad", log_q.size(), log_errors(), NKEYS); end
    bus.core_rdy = '1;
  endtask

  task automatic test_reset_mid();
    int e; bit to;
    set_tabs(3);
    start_run(e);
    for (int n = 0; n < 200 && log_q.size() < 3; n++) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.rdy !== 1'b1 || bus.core_en !== '0 || bus.core_key !== '0 || bus.key !== '0 || bus.key_valid !== 1'b0)
      begin errors++; $display("FAIL midreset_outputs got rdy=%0b en=%b ck=%0d key=%0d v=%0b exp 1/0/0/0/0", bus.rdy, bus.core_en, bus.core_key, bus.key, bus.key_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_run(e);
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL midreset_timeout got timeout exp rdy"); end
    checks++; if (log_q.size() != NKEYS || log_errors() != 0) begin errors++; $display("FAIL midreset_restart got %0d keys %0d bad exp %0d keys 0 bad", log_q.size(), log_errors(), NKEYS); end
  endtask

  task automatic test_en_ignored();
    int e; bit to;
    set_tabs(2);
    start_run(e);
    for (int p = 0; p < 2; p++) begin
      repeat (5) @(negedge clk);
      bus.en = 1'b1;
      @(negedge clk);
      bus.en = 1'b0;
    end
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL en_ignored_timeout got timeout exp rdy"); end
    checks++; if (log_q.size() != NKEYS || log_errors() != 0) begin errors++; $display("FAIL en_ignored_sequence got %0d keys %0d bad exp %0d keys 0 bad", log_q.size(), log_errors(), NKEYS); end
  endtask

  task automatic test_random();
    int e; bit to; bit mv; int mk;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NKEYS; k++) begin
        lat_tab[k] = int'($urandom_range(1, 6));
        hit_tab[k] = ($urandom_range(0, 9) == 0);
      end
      bus.core_rdy = NC'($urandom_range(1, (1 << NC) - 1));
      start_run(e);
      wait_idle(to);
      model_result(mv, mk);
      checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout got timeout exp rdy", r); end
      checks++; if (log_errors() != 0) begin errors++; $display("FAIL rand%0d_dispatch got %0d bad exp 0", r, log_errors()); end
      checks++; if (late_dispatches() != 0) begin errors++; $display("FAIL rand%0d_after_hit got %0d exp 0", r, late_dispatches()); end
      if (first_hit < 0) begin
        checks++; if (log_q.size() != NKEYS) begin errors++; $display("FAIL rand%0d_count got %0d exp %0d", r, log_q.size(), NKEYS); end
      end
      checks++; if (bus.key_valid !== mv) begin errors++; $display("FAIL rand%0d_valid got %0b exp %0b", r, bus.key_valid, mv); end
      checks++; if (int'(bus.key) != mk) begin errors++; $display("FAIL rand%0d_key got %0d exp %0d", r, bus.key, mk); end
`ifdef CRACK_SCHED_STATS_EN
      checks++; if (int'(bus.keys_tried) != log_q.size()) begin errors++; $display("FAIL rand%0d_keys_tried got %0d exp %0d", r, bus.keys_tried, log_q.size()); end
`endif
    end
    bus.core_rdy = '1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1);
  end

  initial begin
    bus.en = 1'b0;
    bus.core_rdy = '1;
    set_tabs(3);
    test_reset();
    test_hit9();
    test_exhaust();
    test_same_cycle_hits();
    test_drain_hit();
    test_core1_not_rdy();
    test_reset_mid();
    test_en_ignored();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
